// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal only when the operand splits into whole chunks.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple adder built from a chain of full-adder cells.
module chunk_add
  import chunked_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: CHUNK bits per clock with a registered inter-chunk carry.
// Define CHUNKED_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NUM_CHUNKS = calc_num_chunks(WIDTH, CHUNK);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] b_acc;
  logic             cin_acc;
  logic             carry_q, cout_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_ch;
  logic             accept, last;

  // Subtraction folds into the add as a + ~b + 1, so the datapath is shared.
`ifdef CHUNKED_ADDER_SUB_EN
  assign b_acc   = sub ? ~b : b;
  assign cin_acc = sub ? 1'b1 : carry_in;
`else
  assign b_acc   = b;
  assign cin_acc = carry_in;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == LAST_IDX);
  assign base   = 32'(idx_q) * 32'(CHUNK);
  assign a_ch   = a_q[base +: CHUNK];
  assign b_ch   = b_q[base +: CHUNK];

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry_q),
    .s    (s_ch),
    .cout (c_ch)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand capture: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b_acc;
    end
  end

  // Chunk stage: one slice of the sum per RUN cycle; idx stops at the last chunk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      carry_q <= cin_acc;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[base +: CHUNK] <= s_ch;
      carry_q              <= c_ch;
      if (last) cout_q <= c_ch;
      else      idx_q  <= idx_q + 1'b1;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed self-checking bench for chunked_serial_adder (WIDTH=32, CHUNK=8).
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
`ifdef CHUNKED_ADDER_SUB_EN
  logic        sub;
`endif

  int checks   = 0;
  int failures = 0;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set (block assumed IDLE), wait for the result, hand it off.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic [31:0] exp_sum, input logic exp_cout);
    int lat;
    a = av; b = bv; carry_in = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; carry_in = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(carry_out), 64'(exp_cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovld_off"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] av, bv;
    logic        cv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_ovld", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(carry_out), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);

    // Full-adder table on bit 0: sum = a+b+cin, never reaches bit 2.
    for (int i = 0; i < 8; i++) begin
      av = {31'd0, i[2]};
      bv = {31'd0, i[1]};
      cv = i[0];
      do_op($sformatf("fa%0d", i), av, bv, cv, 32'(i[2] + i[1] + i[0]), 1'b0);
    end

    do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    do_op("xchunk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    do_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    do_op("mixed", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1);

    // Backpressure: hold DONE for 10 cycles while new operands are offered.
    a = 32'h0000_0010; b = 32'h0000_0020; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    a = 32'h0000_AAAA; b = 32'h0000_5555; carry_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_sum", 64'(sum), 64'h30);
      check("bp_ovld", 64'(out_valid), 64'd1);
      check("bp_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_handoff_rdy", 64'(in_ready), 64'd1);
    check("bp_handoff_ovld", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    do_op("bp_next", 32'h0000_AAAA, 32'h0000_5555, 1'b0, 32'h0000_FFFF, 1'b0);

    // Abort mid-operation after two RUN cycles.
    a = 32'h1212_1212; b = 32'h0101_0101; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_partial", 64'(sum[15:0]), 64'h1313);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_ovld", 64'(out_valid), 64'd0);
    check("mid_sum", 64'(sum), 64'd0);
    check("mid_cout", 64'(carry_out), 64'd0);
    check("mid_rdy", 64'(in_ready), 64'd1);
    tick();
    check("mid_stay_idle", 64'(out_valid), 64'd0);
    do_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

`ifdef CHUNKED_ADDER_SUB_EN
    sub = 1'b1;
    do_op("sub_neg", 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0);
    do_op("sub_pos", 32'd7, 32'd5, 1'b1, 32'd2, 1'b1);
    sub = 1'b0;
    do_op("sub_off", 32'd7, 32'd5, 1'b1, 32'd13, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
